// File: rtl/usb_tx_nrzi_stuffer.sv
// USB transmit back end: bit stuffing, NRZI line encoding and EOP generation.
// Every state change happens on a bit_tick; the D+/D- lines are registered.
module usb_tx_nrzi_stuffer #(
   parameter int STUFF_LIMIT = 6,
   parameter int SE0_BITS    = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic bit_tick,
   input  logic tx_en,
   input  logic serial_in,
   input  logic eop_req,
   output logic stuff_stall,
   output logic dp_out,
   output logic dm_out,
   output logic busy,
   output logic eop_done
);

   localparam int CNT_W = $clog2(STUFF_LIMIT + 1);
   localparam int SE0_W = $clog2(SE0_BITS + 1);
   localparam logic [CNT_W-1:0] ONES_MAX = CNT_W'(STUFF_LIMIT);
   localparam logic [SE0_W-1:0] SE0_LAST = SE0_W'(SE0_BITS);

   typedef enum logic [1:0] {IDLE, DATA, EOP_SE0, EOP_J} state_t;

   state_t             state, state_nxt;
   logic               level, level_nxt;   // 1 = J, 0 = K
   logic [CNT_W-1:0]   ones_cnt, ones_nxt;
   logic [SE0_W-1:0]   se0_cnt, se0_nxt;
   logic               dp_nxt, dm_nxt, done_nxt;
   logic               stuff_pending;

   assign stuff_pending = (state == DATA) && (ones_cnt == ONES_MAX);
   assign stuff_stall   = bit_tick & stuff_pending & ~rst;
   assign busy          = (state != IDLE);

   always_comb begin
      state_nxt = state;
      level_nxt = level;
      ones_nxt  = ones_cnt;
      se0_nxt   = se0_cnt;
      dp_nxt    = dp_out;
      dm_nxt    = dm_out;
      done_nxt  = 1'b0;
      if (bit_tick) begin
         case (state)
            IDLE: begin
               ones_nxt  = '0;
               level_nxt = 1'b1;
               if (tx_en) begin
                  // Starting from J, a 0 toggles to K and a 1 stays on J.
                  level_nxt = serial_in;
                  state_nxt = DATA;
               end
               dp_nxt = level_nxt;
               dm_nxt = ~level_nxt;
            end
            DATA: begin
               if (stuff_pending) begin
                  level_nxt = ~level;
                  ones_nxt  = '0;
               end else if (eop_req) begin
                  state_nxt = EOP_SE0;
                  se0_nxt   = '0;
               end else if (tx_en) begin
                  if (serial_in) begin
                     if (ones_cnt != ONES_MAX) ones_nxt = ones_cnt + CNT_W'(1);
                  end else begin
                     ones_nxt  = '0;
                     level_nxt = ~level;
                  end
               end else begin
                  state_nxt = IDLE;
                  level_nxt = 1'b1;
                  ones_nxt  = '0;
               end
               if (state_nxt == EOP_SE0) begin
                  dp_nxt = 1'b0;
                  dm_nxt = 1'b0;
               end else begin
                  dp_nxt = level_nxt;
                  dm_nxt = ~level_nxt;
               end
            end
            EOP_SE0: begin
               se0_nxt = se0_cnt + SE0_W'(1);
               if (se0_nxt == SE0_LAST) begin
                  state_nxt = EOP_J;
                  level_nxt = 1'b1;
                  dp_nxt    = 1'b1;
                  dm_nxt    = 1'b0;
               end else begin
                  dp_nxt = 1'b0;
                  dm_nxt = 1'b0;
               end
            end
            EOP_J: begin
               state_nxt = IDLE;
               level_nxt = 1'b1;
               se0_nxt   = '0;
               ones_nxt  = '0;
               done_nxt  = 1'b1;
               dp_nxt    = 1'b1;
               dm_nxt    = 1'b0;
            end
            default: begin
               state_nxt = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         level    <= 1'b1;
         ones_cnt <= '0;
         se0_cnt  <= '0;
         dp_out   <= 1'b1;
         dm_out   <= 1'b0;
         eop_done <= 1'b0;
      end else begin
         state    <= state_nxt;
         level    <= level_nxt;
         ones_cnt <= ones_nxt;
         se0_cnt  <= se0_nxt;
         dp_out   <= dp_nxt;
         dm_out   <= dm_nxt;
         eop_done <= done_nxt;
      end
   end

endmodule
